// File: rtl/irq_ctrl.sv
// Edge-latched interrupt controller with a four-byte register window, one
// request in flight at a time, and an idle gap enforced after end-of-interrupt.
module irq_ctrl #(
  parameter int          N_SRC = 3,
  parameter logic [15:0] BASE  = 16'd980,
  parameter int          GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic [15:0]      bus_addr,
  input  logic             bus_we,
  input  logic [7:0]       bus_din,
  output logic [7:0]       bus_dout,
  input  logic             user_mode,
  output logic             irq_req,
  output logic [2:0]       irq_id,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic [1:0]       dbg_state
);

  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [N_SRC-1:0]   mask_q;
  logic [N_SRC-1:0]   src_q;
  logic               primed_q;
  logic               ctrl_en_q;
  logic [7:0]         isr_q;
  logic [GW-1:0]      gap_q;
  logic [2:0]         id_q;
  logic               req_q;
  logic [7:0]         dout_q;

  logic [15:0]        off;
  logic               hit_pend, hit_mask, hit_isr, hit_ctrl;
  logic [N_SRC-1:0]   rise, w1c, cand, ack_clr;
  logic [7:0]         pend8, mask8, rd_data;
  logic [2:0]         pick_id;
  logic               gap_zero, take, ack_take, eoi_take;
  logic               unused_din;

  assign off      = bus_addr - BASE;
  assign hit_pend = (off == 16'd0);
  assign hit_mask = (off == 16'd1);
  assign hit_isr  = (off == 16'd2);
  assign hit_ctrl = (off == 16'd3);

  // The first edge after reset only primes src_q, so a source held high
  // through reset release is not mistaken for a fresh edge.
  assign rise     = primed_q ? (src & ~src_q) : '0;
  assign w1c      = (bus_we && hit_pend) ? bus_din[N_SRC-1:0] : '0;
  assign cand     = pend_q & mask_q;
  assign gap_zero = (GAP == 0) || (gap_q == '0);
  assign unused_din = ^bus_din;

  always_comb begin
    pend8 = '0;
    mask8 = '0;
    pend8[N_SRC-1:0] = pend_q;
    mask8[N_SRC-1:0] = mask_q;
  end

  // Lowest set index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    pick_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) pick_id = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    ack_take = 1'b0;
    eoi_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en_q && (|cand) && user_mode && gap_zero) begin
          state_d = REQ;
          take    = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d  = SERVICE;
          ack_take = 1'b1;
        end else if (!(pend8[id_q] && mask8[id_q]) || !ctrl_en_q || !user_mode) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_eoi) begin
          state_d  = IDLE;
          eoi_take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_take && (id_q == 3'(i));
    end
  end

  // New edges are OR-ed in last so they beat both W1C and the ack clear.
  assign pend_d = (pend_q & ~w1c & ~ack_clr) | rise;

  always_comb begin
    rd_data = 8'h00;
    if (hit_pend)      rd_data = pend8;
    else if (hit_mask) rd_data = mask8;
    else if (hit_isr)  rd_data = isr_q;
    else if (hit_ctrl) rd_data = {7'd0, ctrl_en_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      src_q     <= '0;
      primed_q  <= 1'b0;
      ctrl_en_q <= 1'b0;
      isr_q     <= 8'hFF;
      gap_q     <= '0;
      id_q      <= '0;
      req_q     <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      src_q    <= src;
      primed_q <= 1'b1;
      req_q    <= (state_d == REQ);
      dout_q   <= rd_data;
      if (bus_we && hit_mask) mask_q <= bus_din[N_SRC-1:0];
      if (bus_we && hit_ctrl) ctrl_en_q <= bus_din[0];
      if (take) id_q <= pick_id;
      if (ack_take)      isr_q <= {5'd0, id_q};
      else if (eoi_take) isr_q <= 8'hFF;
      if (eoi_take && (GAP > 0)) gap_q <= GW'(GAP);
      else if (gap_q != '0)      gap_q <= gap_q - GW'(1);
    end
  end

  assign bus_dout  = dout_q;
  assign irq_req   = req_q;
  assign irq_id    = id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector bench for irq_ctrl: a table of per-cycle inputs and expected
// outputs, followed by a hand-written reset-during-service sequence.
module tb_irq_ctrl;

  localparam logic [15:0] A_PEND = 16'd980;
  localparam logic [15:0] A_MASK = 16'd981;
  localparam logic [15:0] A_ISR  = 16'd982;
  localparam logic [15:0] A_CTRL = 16'd983;
  localparam logic [15:0] A_NONE = 16'd984;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic        user_mode;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;
  logic        irq_eoi;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .src(src), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_din(bus_din), .bus_dout(bus_dout), .user_mode(user_mode),
    .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_eoi(irq_eoi),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  src;
    logic        um;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        ack;
    logic        eoi;
    logic        exp_req;
    logic [2:0]  exp_id;
    logic [1:0]  exp_st;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] s, logic um, logic we, logic [15:0] a,
                              logic [7:0] d, logic ack, logic eoi, logic req,
                              logic [2:0] id, logic [1:0] st, logic [7:0] dout);
    vec_t v;
    v.src = s; v.um = um; v.we = we; v.addr = a; v.din = d; v.ack = ack;
    v.eoi = eoi; v.exp_req = req; v.exp_id = id; v.exp_st = st; v.exp_dout = dout;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    src = 3'b000; bus_addr = A_NONE; bus_we = 1'b0; bus_din = 8'h00;
    irq_ack = 1'b0; irq_eoi = 1'b0;
  endtask

  initial begin
    // src um we addr din ack eoi | req id st dout
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,0,0,8'hFF)); // r0 reset ISR
    vecs.push_back(mk(3'b000,1,0,A_CTRL,8'h00,0,0, 0,0,0,8'h00)); // r1
    vecs.push_back(mk(3'b000,1,0,A_MASK,8'h00,0,0, 0,0,0,8'h00)); // r2
    vecs.push_back(mk(3'b000,1,1,A_MASK,8'h07,0,0, 0,0,0,8'h00)); // v0
    vecs.push_back(mk(3'b000,1,1,A_CTRL,8'h01,0,0, 0,0,0,8'h00)); // v1
    vecs.push_back(mk(3'b000,1,0,A_CTRL,8'h00,0,0, 0,0,0,8'h01)); // v2
    vecs.push_back(mk(3'b000,1,0,A_MASK,8'h00,0,0, 0,0,0,8'h07)); // v3
    vecs.push_back(mk(3'b010,1,0,A_PEND,8'h00,0,0, 0,0,0,8'h00)); // v4 src1 rises
    vecs.push_back(mk(3'b010,1,0,A_PEND,8'h00,0,0, 1,1,1,8'h02)); // v5 request id1
    vecs.push_back(mk(3'b010,1,0,A_ISR ,8'h00,1,0, 0,1,2,8'hFF)); // v6 ack
    vecs.push_back(mk(3'b010,1,0,A_ISR ,8'h00,0,0, 0,1,2,8'h01)); // v7
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,0, 0,1,2,8'h00)); // v8
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,1, 0,1,0,8'h01)); // v9 eoi
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,1,0,8'hFF)); // v10 gap
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,1,0,8'hFF)); // v11
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,1,0,8'hFF)); // v12
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,1,0,8'hFF)); // v13
    vecs.push_back(mk(3'b101,1,0,A_PEND,8'h00,0,0, 0,1,0,8'h00)); // v14 src0+src2
    vecs.push_back(mk(3'b101,1,0,A_PEND,8'h00,0,0, 1,0,1,8'h05)); // v15 id0 first
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,1,0, 0,0,2,8'h05)); // v16 ack
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,0,2,8'h00)); // v17
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,1, 0,0,0,8'h04)); // v18 eoi
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,0,0,8'hFF)); // v19 gap
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,0, 0,0,0,8'h04)); // v20
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,0, 0,0,0,8'h04)); // v21
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,0, 0,0,0,8'h04)); // v22
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,0, 1,2,1,8'h04)); // v23 id2
    vecs.push_back(mk(3'b000,1,1,A_PEND,8'h04,0,0, 1,2,1,8'h04)); // v24 W1C bit2
    vecs.push_back(mk(3'b000,1,0,A_ISR ,8'h00,0,0, 0,2,0,8'hFF)); // v25 withdrawn
    vecs.push_back(mk(3'b001,1,0,A_PEND,8'h00,0,0, 0,2,0,8'h00)); // v26 src0 rises
    vecs.push_back(mk(3'b001,1,0,A_PEND,8'h00,0,0, 1,0,1,8'h01)); // v27 id0
    vecs.push_back(mk(3'b001,1,1,A_PEND,8'h01,0,0, 1,0,1,8'h01)); // v28 W1C bit0
    vecs.push_back(mk(3'b001,1,0,A_ISR ,8'h00,0,0, 0,0,0,8'hFF)); // v29 withdrawn
    vecs.push_back(mk(3'b100,0,0,A_PEND,8'h00,0,0, 0,0,0,8'h00)); // v30 kernel
    vecs.push_back(mk(3'b100,0,0,A_PEND,8'h00,0,0, 0,0,0,8'h04)); // v31 held off
    vecs.push_back(mk(3'b100,0,0,A_PEND,8'h00,0,0, 0,0,0,8'h04)); // v32
    vecs.push_back(mk(3'b100,1,0,A_PEND,8'h00,0,0, 1,2,1,8'h04)); // v33 user mode
    vecs.push_back(mk(3'b100,0,0,A_PEND,8'h00,0,0, 0,2,0,8'h04)); // v34 withdraw
    vecs.push_back(mk(3'b100,0,1,A_PEND,8'h04,0,0, 0,2,0,8'h04)); // v35 clear
    vecs.push_back(mk(3'b100,1,0,A_PEND,8'h00,0,0, 0,2,0,8'h00)); // v36
    vecs.push_back(mk(3'b001,1,1,A_PEND,8'h01,0,0, 0,2,0,8'h00)); // v37 set vs W1C
    vecs.push_back(mk(3'b001,1,0,A_PEND,8'h00,0,0, 1,0,1,8'h01)); // v38
    vecs.push_back(mk(3'b000,1,0,A_PEND,8'h00,0,0, 1,0,1,8'h01)); // v39
    vecs.push_back(mk(3'b001,1,0,A_PEND,8'h00,1,0, 0,0,2,8'h01)); // v40 ack + edge
    vecs.push_back(mk(3'b001,1,0,A_PEND,8'h00,0,0, 0,0,2,8'h01)); // v41 PEND kept
    vecs.push_back(mk(3'b001,1,0,A_ISR ,8'h00,0,0, 0,0,2,8'h00)); // v42
    vecs.push_back(mk(3'b001,1,0,A_ISR ,8'h00,1,0, 0,0,2,8'h00)); // v43 stray ack
    vecs.push_back(mk(3'b001,1,0,A_NONE,8'h00,0,0, 0,0,2,8'h00)); // v44 unmapped
    vecs.push_back(mk(3'b001,1,1,A_ISR ,8'h05,0,0, 0,0,2,8'h00)); // v45 ISR write
    vecs.push_back(mk(3'b001,1,0,A_ISR ,8'h00,0,0, 0,0,2,8'h00)); // v46 unchanged
    vecs.push_back(mk(3'b001,1,1,A_CTRL,8'hFF,0,0, 0,0,2,8'h01)); // v47
    vecs.push_back(mk(3'b001,1,0,A_CTRL,8'h00,0,0, 0,0,2,8'h01)); // v48 bits7:1=0

    rst_n = 1'b0;
    user_mode = 1'b1;
    idle_inputs();
    #3;
    chk("reset irq_req", 32'(irq_req), 32'd0);
    chk("reset irq_id", 32'(irq_id), 32'd0);
    chk("reset bus_dout", 32'(bus_dout), 32'h00);
    chk("reset state", 32'(dbg_state), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    foreach (vecs[i]) begin
      src = vecs[i].src; user_mode = vecs[i].um; bus_we = vecs[i].we;
      bus_addr = vecs[i].addr; bus_din = vecs[i].din;
      irq_ack = vecs[i].ack; irq_eoi = vecs[i].eoi;
      tick();
      chk($sformatf("vec%0d irq_req", i), 32'(irq_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d irq_id", i), 32'(irq_id), 32'(vecs[i].exp_id));
      chk($sformatf("vec%0d state", i), 32'(dbg_state), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d bus_dout", i), 32'(bus_dout), 32'(vecs[i].exp_dout));
    end

    // Reset asserted mid-cycle while in SERVICE, with sources held high.
    idle_inputs();
    #2;
    src = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("midsvc irq_req", 32'(irq_req), 32'd0);
    chk("midsvc state", 32'(dbg_state), 32'd0);
    chk("midsvc bus_dout", 32'(bus_dout), 32'h00);
    chk("midsvc isr", 32'(dut.isr_q), 32'hFF);
    tick();
    tick();
    rst_n = 1'b1;
    bus_addr = A_MASK;
    tick();
    chk("post-reset MASK", 32'(bus_dout), 32'h00);
    chk("post-reset irq_req", 32'(irq_req), 32'd0);
    bus_addr = A_PEND;
    tick();
    chk("post-reset PEND held src", 32'(bus_dout), 32'h00);
    bus_addr = A_ISR;
    tick();
    chk("post-reset ISR", 32'(bus_dout), 32'hFF);
    chk("post-reset state", 32'(dbg_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 3, giving the number of interrupt sources, legal range 1..8.
REQ-002 The block SHALL have parameter BASE, default 16'd980, giving the first address of the four-byte register window.
REQ-003 The block SHALL have parameter GAP, default 4, giving the minimum idle cycles between end-of-interrupt and the next request.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port src, input, N_SRC bits: interrupt sources, rising-edge sensitive; bit 0 is timer1, bit 1 is timer2, bit 2 is key.
REQ-007 The block SHALL have port bus_addr, input, 16 bits: CPU data address.
REQ-008 The block SHALL have port bus_we, input, 1 bit: CPU write strobe.
REQ-009 The block SHALL have port bus_din, input, 8 bits: CPU write data.
REQ-010 The block SHALL have port bus_dout, output, 8 bits: registered read data.
REQ-011 The block SHALL have port user_mode, input, 1 bit: 1 when the CPU runs in user mode.
REQ-012 The block SHALL have port irq_req, output, 1 bit: interrupt request to the core.
REQ-013 The block SHALL have port irq_id, output, 3 bits: index of the requested source.
REQ-014 The block SHALL have port irq_ack, input, 1 bit: single-cycle pulse, core took the interrupt.
REQ-015 The block SHALL have port irq_eoi, input, 1 bit: single-cycle pulse, core executed interrupt-return.

Function
REQ-016 The block SHALL map registers as follows.
- BASE+0 PEND: read; write-1-to-clear.
- BASE+1 MASK: read/write.
- BASE+2 ISR: read-only; in-service id, 0xFF when none.
- BASE+3 CTRL: bit0 is global enable; bits 7:1 read 0.
REQ-017 Reads SHALL have one-cycle latency: bus_dout after edge k reflects bus_addr at edge k, from register state before edge k; unmapped addresses return 0x00.
REQ-018 Writes SHALL take effect at the edge where bus_we=1; writes to unmapped addresses and to ISR SHALL be ignored.
REQ-019 src SHALL be registered into src_q each cycle; at the edge where src[i]=1 and src_q[i]=0, PEND[i] SHALL be set.
REQ-020 If a PEND set and a W1C of the same bit coincide, set SHALL win.
REQ-021 MASK SHALL gate arbitration only; PEND SHALL latch edges regardless of MASK and CTRL.
REQ-022 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-023 IDLE -> REQ SHALL occur when all of the following hold: CTRL.en=1, (PEND&MASK)!=0, user_mode=1, gap counter=0. Arbitration SHALL select the lowest set index of PEND&MASK and latch it into irq_id.
REQ-024 irq_req SHALL be a registered output, 1 exactly while in REQ; irq_id SHALL hold its latched value through REQ and SERVICE.
REQ-025 REQ -> SERVICE SHALL occur on irq_ack=1: clear PEND[irq_id] and set ISR=irq_id. A new edge on the same source in that cycle SHALL leave PEND[irq_id]=1.
REQ-026 REQ -> IDLE SHALL occur (withdraw), without ack, if PEND[irq_id]&MASK[irq_id] becomes 0, CTRL.en becomes 0, or user_mode becomes 0. Ack SHALL take priority over withdrawal in the same cycle.
REQ-027 SERVICE -> IDLE SHALL occur on irq_eoi=1: ISR=0xFF and the gap counter loaded with GAP. No nesting; new edges only set PEND while in SERVICE.
REQ-028 The gap counter SHALL decrement by 1 per cycle while nonzero, saturating at 0, and SHALL be ignored when GAP=0.
REQ-029 irq_ack outside REQ and irq_eoi outside SERVICE SHALL be ignored.
REQ-030 Latency: a source edge sampled at edge k with all conditions true SHALL give PEND=1 after edge k and irq_req=1 after edge k+1.

Reset
REQ-031 While rst_n=0 the following SHALL hold asynchronously.
- Outputs: irq_req=0, irq_id=0, bus_dout=0x00.
- Registers: PEND=0, MASK=0, CTRL=0, ISR=0xFF, src_q=0, gap counter=0.
- State: IDLE.
REQ-032 Reset asserted in REQ or SERVICE SHALL abort the interrupt with no ack or eoi required; a src held high through reset release SHALL NOT set PEND.

Verification
REQ-033 The bench SHALL cover basic flow: MASK=0x07, CTRL=1, user_mode=1, src[1] rises at edge 10 -> PEND=0x02 after edge 10, irq_req=1 with irq_id=1 after edge 11; ack -> ISR reads 0x01, PEND 0x00.
REQ-034 The bench SHALL cover priority: src[2] and src[0] rise on the same edge -> irq_id=0 first; after eoi plus 4 gap cycles -> irq_id=2.
REQ-035 The bench SHALL cover withdrawal: in REQ, write 0x01 to BASE+0 clearing the requested bit 0 -> irq_req=0 on the next cycle, state IDLE, no ISR change.
REQ-036 The bench SHALL cover kernel hold-off: user_mode=0 with PEND&MASK=0x04 -> irq_req stays 0; user_mode -> 1 -> irq_req=1 one cycle later.
REQ-037 The bench SHALL cover the W1C/set collision: write 0x01 to BASE+0 on the same edge as src[0] rises -> PEND[0]=1.
REQ-038 The bench SHALL cover reset mid-SERVICE: rst_n=0 -> ISR=0xFF, irq_req=0 immediately; read of BASE+1 after release -> 0x00.
